fifo_push_arbiter: RTL and testbench

Round-robin write arbiter that shares one FIFO write port among several producers. Each cycle it selects at most one requesting producer, drives the FIFO `push`/`DataInput` pair from that producer's data, and returns a one-hot grant. A granted producer may keep ownership for a bounded burst of back-to-back pushes. The block sits directly in front of the FIFO write side and observes its `full` flag for backpressure.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/rr_priority_picker.sv | 27 ++
 rtl/fifo_push_arbiter.sv | 94 +++++++++
 tb/tb_fifo_push_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO helpers and arbiter state encoding
package fifo_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  function automatic int CeilLog2(input int x);
    int r;
    r = 0;
    for (int v = x - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first requester at or after rr_ptr, wrapping N-1 to 0
module rr_priority_picker
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = CeilLog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          valid
);
  // scan furthest-first so the nearest requester overwrites and wins
  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N]) begin
        pick  = N'(1) << ((int'(rr_ptr) + k) % N);
        idx   = PW'((int'(rr_ptr) + k) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_push_arbiter
  import fifo_pkg::*;
#(
  parameter int Word_Length          = 16,
  parameter int Number_Of_Requesters = 4,
  parameter int Max_Burst            = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [Number_Of_Requesters-1:0]             req,
  input  logic [Number_Of_Requesters*Word_Length-1:0] ReqData,
  input  logic                                        full,
  output logic [Number_Of_Requesters-1:0]             grant,
  output logic                                        push,
  output logic [Word_Length-1:0]                      DataInput,
  output logic [CeilLog2(Number_Of_Requesters)-1:0]   owner,
  output logic                                        busy
);
  localparam int N  = Number_Of_Requesters;
  localparam int PW = CeilLog2(N);
  localparam int CW = CeilLog2(Max_Burst) + 1;
  localparam logic [CW-1:0] MAXB = CW'(Max_Burst);

  arb_state_t    r_state, w_state;
  logic [PW-1:0] r_rr_ptr, w_rr_ptr, r_owner, w_owner, w_idx;
  logic [CW-1:0] r_burst_cnt, w_burst_cnt;
  logic [N-1:0]  w_pick;
  logic          w_valid, w_owner_req;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + 1'b1;
  endfunction

  rr_priority_picker #(.N(N), .PW(PW)) u_pick (
    .req   (req),
    .rr_ptr(r_rr_ptr),
    .pick  (w_pick),
    .idx   (w_idx),
    .valid (w_valid)
  );

  assign w_owner_req = req[r_owner];
  assign grant = reset ? '0
               : (r_state == IDLE) ? (full ? '0 : w_pick)
               : (w_owner_req && !full) ? N'(1) << r_owner : '0;
  assign push  = |grant;
  assign owner = r_owner;
  assign busy  = r_state == BURST;

  always_comb begin
    DataInput = '0;
    for (int i = 0; i < N; i++) DataInput |= grant[i] ? ReqData[i*Word_Length +: Word_Length] : '0;
  end

  always_comb begin
    w_state     = r_state;
    w_rr_ptr    = r_rr_ptr;
    w_owner     = r_owner;
    w_burst_cnt = r_burst_cnt;
    if (r_state == IDLE) begin
      if (!full && w_valid) begin
        w_owner = w_idx;
        if (Max_Burst > 1) begin
          w_state     = BURST;
          w_burst_cnt = CW'(1);
        end else w_rr_ptr = inc(w_idx);
      end
    end else if (!w_owner_req) begin
      w_state  = IDLE;
      w_rr_ptr = inc(r_owner);
    end else if (!full) begin
      w_burst_cnt = r_burst_cnt + 1'b1;
      if (w_burst_cnt == MAXB) begin
        w_state  = IDLE;
        w_rr_ptr = inc(r_owner);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_rr_ptr    <= w_rr_ptr;
      r_owner     <= w_owner;
      r_burst_cnt <= w_burst_cnt;
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed checks of burst round-robin arbitration
module tb_fifo_push_arbiter;
  localparam int N = 4, W = 16;
  logic clk = 1'b0, reset = 1'b1, full = 1'b0;
  logic [N-1:0] req = '0, req1 = '0;
  logic [N*W-1:0] data = {16'd4, 16'd3, 16'd2, 16'd1};
  logic [N-1:0] grant, grant1;
  logic push, push1, busy, busy1;
  logic [W-1:0] din, din1;
  logic [1:0] owner, owner1;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];

  fifo_push_arbiter #(.Word_Length(W), .Number_Of_Requesters(N), .Max_Burst(2)) dut (
    .clk(clk), .reset(reset), .req(req), .ReqData(data), .full(full),
    .grant(grant), .push(push), .DataInput(din), .owner(owner), .busy(busy));

  fifo_push_arbiter #(.Word_Length(W), .Number_Of_Requesters(N), .Max_Burst(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .ReqData(data), .full(1'b0),
    .grant(grant1), .push(push1), .DataInput(din1), .owner(owner1), .busy(busy1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (push) q.push_back(din);
    @(posedge clk);
    #1;
    full = (q.size() >= 8);
  endtask

  initial begin
    req = 4'b1111;
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_data", 32'(din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = 4'b0000;
    #1;
    chk("idle_grant", 32'(grant), 0);
    chk("idle_push", 32'(push), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_owner", 32'(owner), 0);
    tick();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("seq_grant", 32'(grant), 32'(1) << (k / 2));
      chk("seq_data", 32'(din), 32'(k / 2 + 1));
      chk("seq_busy", 32'(busy), 32'(k % 2));
      tick();
    end
    for (int k = 0; k < 8; k++) chk("fifo_word", 32'(q[k]), 32'(k / 2 + 1));
    req = 4'b0010;
    #1;
    chk("full_grant", 32'(grant), 0);
    chk("full_push", 32'(push), 0);
    tick();
    void'(q.pop_front());
    full = 1'b0;
    #1;
    chk("unfull_grant", 32'(grant), 32'b0010);
    chk("unfull_data", 32'(din), 2);
    tick();
    q.delete();
    full = 1'b0;
    req = 4'b0000;
    #1;
    chk("drop_grant", 32'(grant), 0);
    chk("drop_busy", 32'(busy), 1);
    tick();
    chk("drop_idle", 32'(busy), 0);
    req = 4'b0100;
    #1;
    chk("p2_grant", 32'(grant), 32'b0100);
    chk("p2_data", 32'(din), 3);
    tick();
    req = 4'b0000;
    #1;
    chk("bubble_grant", 32'(grant), 0);
    chk("bubble_busy", 32'(busy), 1);
    tick();
    chk("post_bubble_busy", 32'(busy), 0);
    chk("post_bubble_owner", 32'(owner), 2);
    req = 4'b1001;
    #1;
    chk("rr3_grant", 32'(grant), 32'b1000);
    chk("rr3_data", 32'(din), 4);
    tick();
    req = 4'b0000;
    #1;
    tick();
    req = 4'b0010;
    #1;
    chk("p1_grant", 32'(grant), 32'b0010);
    tick();
    chk("p1_owner", 32'(owner), 1);
    chk("p1_busy", 32'(busy), 1);
    req = 4'b0011;
    #1;
    chk("p1_burst_grant", 32'(grant), 32'b0010);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_push", 32'(push), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_owner", 32'(owner), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("postrst_grant", 32'(grant), 32'(1) << (k / 2));
      tick();
      #1;
    end
    req = 4'b0000;
    q.delete();
    req1 = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mb1_grant", 32'(grant1), (k % 2) ? 32'b0100 : 32'b0001);
      chk("mb1_busy", 32'(busy1), 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
